// File: rtl/golden_nonce_uart_tx_if.sv
// rtl/golden_nonce_uart_tx_if.sv - golden nonce input and UART status bundle
interface golden_nonce_uart_tx_if #(
  parameter int FIFO_DEPTH_LOG2 = 2
);
  logic                     nonce_valid;
  logic [31:0]              nonce_in;
  logic                     uart_tx;
  logic                     busy;
  logic                     overflow;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;

  modport master (
    output nonce_valid, nonce_in,
    input  uart_tx, busy, overflow, fifo_count
  );

  modport slave (
    input  nonce_valid, nonce_in,
    output uart_tx, busy, overflow, fifo_count
  );
endinterface

// File: rtl/golden_nonce_uart_tx.sv
// rtl/golden_nonce_uart_tx.sv - buffered golden nonce sender over UART 8N1
module golden_nonce_uart_tx #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                   hash_clk,
  input  logic                   reset,
  golden_nonce_uart_tx_if.slave  bus
);
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nx;
  logic [15:0] tick, tick_nx;
  logic [2:0]  bit_idx, bit_idx_nx;
  logic [1:0]  byte_idx, byte_idx_nx;
  logic [31:0] shreg, shreg_nx;
  logic        tx_q, tx_nx;
  logic        busy_q;
  logic        ovf_q;

  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, count;
  logic        full, pop, push, drop, tick_end;
  logic [7:0]  cur_byte;

  // Pointers are one bit wider than the address so full and empty differ.
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == FULL_COUNT);
  assign pop       = (state == IDLE) && (count != '0);
  assign push      = bus.nonce_valid && (!full || pop);
  assign drop      = bus.nonce_valid && full && !pop;
  assign wr_ptr_nx = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nx = rd_ptr + {{AW{1'b0}}, pop};
  assign tick_end  = (tick == BIT_LAST);
  // The byte on the wire is always the top byte; the register shifts by 8 between bytes.
  assign cur_byte  = shreg[31:24];

  assign bus.uart_tx    = tx_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = ovf_q;
  assign bus.fifo_count = count;

  // Next-state, bit timing and next line level for the frame sequencer.
  always_comb begin
    state_nx    = state;
    tick_nx     = tick;
    bit_idx_nx  = bit_idx;
    byte_idx_nx = byte_idx;
    shreg_nx    = shreg;
    tx_nx       = tx_q;
    case (state)
      IDLE: begin
        tx_nx   = 1'b1;
        tick_nx = '0;
        if (pop) begin
          shreg_nx    = mem[rd_ptr[AW-1:0]];
          byte_idx_nx = '0;
          state_nx    = START;
          tx_nx       = 1'b0;
        end
      end
      START: begin
        if (tick_end) begin
          tick_nx    = '0;
          bit_idx_nx = '0;
          state_nx   = DATA;
          tx_nx      = cur_byte[0];
        end else begin
          tick_nx = tick + 16'd1;
        end
      end
      DATA: begin
        if (tick_end) begin
          tick_nx = '0;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            tx_nx      = cur_byte[bit_idx + 3'd1];
          end
        end else begin
          tick_nx = tick + 16'd1;
        end
      end
      STOP: begin
        if (tick_end) begin
          tick_nx = '0;
          if (byte_idx != 2'd3) begin
            byte_idx_nx = byte_idx + 2'd1;
            shreg_nx    = shreg << 8;
            state_nx    = START;
            tx_nx       = 1'b0;
          end else begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
          end
        end else begin
          tick_nx = tick + 16'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end

  // Sequencer registers; reset forces the line high immediately.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      tick     <= tick_nx;
      bit_idx  <= bit_idx_nx;
      byte_idx <= byte_idx_nx;
      shreg    <= shreg_nx;
      tx_q     <= tx_nx;
      busy_q   <= ((wr_ptr_nx - rd_ptr_nx) != '0) || (state_nx != IDLE);
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
      ovf_q  <= ovf_q | drop;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge hash_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.nonce_in;
    end
  end
endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// tb/tb_golden_nonce_uart_tx.sv - randomized self-checking bench for golden_nonce_uart_tx
module tb_golden_nonce_uart_tx;
  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 40 * CPB;

  logic hash_clk = 1'b0;
  logic reset;

  always #5 hash_clk = ~hash_clk;

  golden_nonce_uart_tx_if #(.FIFO_DEPTH_LOG2(AW)) bus ();

  golden_nonce_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH_LOG2(AW)
  ) dut (
    .hash_clk(hash_clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of waiting nonces and the time of the last pop.
  int          e        = 0;
  int          next_pop = 0;
  int          last_pop = -100000;
  logic [31:0] mq[$];
  logic [31:0] cur      = '0;
  logic        exp_ovf  = 1'b0;
  logic [7:0]  exp_bytes[$];

  // Line decoder state.
  bit          rx_act  = 1'b0;
  int          rx_t    = 0;
  logic [7:0]  rx_byte = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h edge=%0d", tag, got, exp, e);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_bytes.delete();
    exp_ovf  = 1'b0;
    next_pop = 0;
    last_pop = -100000;
    rx_act   = 1'b0;
    rx_t     = 0;
  endtask

  task automatic decode();
    int b;
    if (!rx_act && bus.uart_tx == 1'b0) begin
      rx_act = 1'b1;
      rx_t   = 0;
    end
    if (rx_act) begin
      if (rx_t % CPB == CPB / 2) begin
        b = rx_t / CPB;
        if (b == 0) begin
          check("rx_start_bit", bus.uart_tx, 0);
        end else if (b <= 8) begin
          rx_byte[b-1] = bus.uart_tx;
        end else begin
          check("rx_stop_bit", bus.uart_tx, 1);
          check("rx_byte_expected", exp_bytes.size() != 0, 1);
          if (exp_bytes.size() != 0) check("rx_byte", rx_byte, exp_bytes.pop_front());
          rx_act = 1'b0;
        end
      end
      rx_t++;
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    bit         pop, full, exp_busy;
    logic       exp_tx;
    logic [7:0] by;
    int         k, b, pos;
    bus.nonce_valid = v;
    bus.nonce_in    = d;
    @(posedge hash_clk);
    e++;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && (e >= next_pop);
    if (pop) begin
      cur      = mq.pop_front();
      last_pop = e;
      next_pop = e + FRAME + 1;
      for (int i = 3; i >= 0; i--) exp_bytes.push_back(cur[8*i +: 8]);
    end
    if (v) begin
      if (!full || pop) mq.push_back(d);
      else exp_ovf = 1'b1;
    end
    #1;
    bus.nonce_valid = 1'b0;
    k      = e - last_pop;
    exp_tx = 1'b1;
    if (k < FRAME) begin
      b   = k / CPB;
      pos = b % 10;
      by  = 8'(cur >> (24 - 8 * (b / 10)));
      if (pos == 0) exp_tx = 1'b0;
      else if (pos < 9) exp_tx = by[pos-1];
    end
    exp_busy = (mq.size() != 0) || (k < FRAME);
    check("uart_tx", bus.uart_tx, exp_tx);
    check("busy", bus.busy, exp_busy);
    check("fifo_count", bus.fifo_count, mq.size());
    check("overflow", bus.overflow, exp_ovf);
    decode();
  endtask

  task automatic drain();
    for (int i = 0; i < (DEPTH + 2) * (FRAME + 1) + 10; i++) begin
      if (mq.size() == 0 && (e - last_pop) >= FRAME + 2) break;
      step(1'b0, '0);
    end
    check("drain_bytes_left", exp_bytes.size(), 0);
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_uart_tx", bus.uart_tx, 1);
    check("rst_fifo_count", bus.fifo_count, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_busy", bus.busy, 0);
    model_reset();
    repeat (2) @(posedge hash_clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int t;
    bit burst;
    logic [31:0] d;
    reset           = 1'b1;
    bus.nonce_valid = 1'b0;
    bus.nonce_in    = '0;
    repeat (2) @(posedge hash_clk);
    #1;
    check("init_uart_tx", bus.uart_tx, 1);
    check("init_busy", bus.busy, 0);
    check("init_fifo_count", bus.fifo_count, 0);
    check("init_overflow", bus.overflow, 0);
    #2;
    reset = 1'b0;

    // Idle line after reset.
    repeat (100) step(1'b0, '0);

    // Single nonce: latency and frame end.
    step(1'b1, 32'h12345678);
    t = e;
    while (e < t + FRAME + 1) step(1'b0, '0);
    check("single_busy_end", bus.busy, 0);
    check("single_line_end", bus.uart_tx, 1);
    drain();

    // Four back-to-back nonces.
    step(1'b1, 32'hA5A5A5A5);
    step(1'b1, 32'h00000000);
    step(1'b1, 32'hFFFFFFFF);
    step(1'b1, 32'hDEADBEEF);
    drain();

    // Six strobes: sixth dropped, overflow sticky.
    for (int i = 1; i <= 6; i++) step(1'b1, 32'(i));
    drain();
    check("overflow_sticky", bus.overflow, 1);
    pulse_reset();
    repeat (5) step(1'b0, '0);

    // Push while full on the very edge the idle sequencer pops.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i));
    for (int i = 0; i < 2 * FRAME && (e + 1) != next_pop; i++) step(1'b0, '0);
    step(1'b1, 32'hCAFE0005);
    check("full_pop_count", bus.fifo_count, 4);
    check("full_pop_overflow", bus.overflow, 0);
    drain();

    // Reset in the middle of the second byte with two nonces queued.
    step(1'b1, 32'h11223344);
    step(1'b1, 32'h55667788);
    step(1'b1, 32'h99AABBCC);
    for (int i = 0; i < FRAME && (e - last_pop) != 50; i++) step(1'b0, '0);
    check("pre_reset_count", bus.fifo_count, 2);
    pulse_reset();
    repeat (200) step(1'b0, '0);

    // Randomized traffic with occasional bursts.
    burst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) burst = ~burst;
      case ($urandom_range(0, 7))
        0:       d = 32'h00000000;
        1:       d = 32'hFFFFFFFF;
        default: d = $urandom;
      endcase
      step($urandom_range(0, 99) < (burst ? 60 : 2), d);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
